// File: rtl/wb_result_arbiter.sv
// rtl/wb_result_arbiter.sv - round-robin arbiter sharing the scoreboard write-back port among FUs
// Result types shared with the scoreboard, followed by the arbiter itself.

package tortoise_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] cause;
      logic [31:0] tval;
   } exception_t;

   typedef struct packed {
      logic [2:0]  trans_id;
      logic [4:0]  rd;
      logic [31:0] result;
      exception_t  ex;
   } fu_result_t;

endpackage

module wb_result_arbiter #(
   parameter int unsigned NR_FU = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  flush_i,
   input  logic                    [NR_FU-1:0]   fu_valid_i,
   input  tortoise_pkg::fu_result_t [NR_FU-1:0]  fu_result_i,
   output logic                    [NR_FU-1:0]   fu_ready_o,
   output logic                                  wb_valid_o,
   output tortoise_pkg::fu_result_t              wb_result_o,
   input  logic                                  wb_ready_i
);

   localparam int unsigned PTR_W = $clog2(NR_FU);

   logic                     out_valid_q;
   tortoise_pkg::fu_result_t out_data_q;
   logic [PTR_W-1:0]         rr_ptr_q;

   logic                     slot_free;
   logic                     hit;
   logic                     grant;
   logic [PTR_W-1:0]         winner;
   logic [PTR_W-1:0]         cand;
   logic [PTR_W-1:0]         rr_ptr_d;
   int unsigned              idx;

   // A slot draining this cycle may be refilled on the same edge.
   assign slot_free = ~out_valid_q | wb_ready_i;

   always_comb begin
      hit    = 1'b0;
      winner = '0;
      cand   = '0;
      idx    = 0;
      for (int unsigned i = 0; i < NR_FU; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= NR_FU) begin
            idx = idx - NR_FU;
         end
         cand = PTR_W'(idx);
         if (!hit && fu_valid_i[cand]) begin
            hit    = 1'b1;
            winner = cand;
         end
      end
   end

   assign grant    = slot_free & ~flush_i & hit;
   assign rr_ptr_d = (winner == PTR_W'(NR_FU - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      fu_ready_o = '0;
      if (grant) begin
         fu_ready_o[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rr_ptr_q    <= '0;
      end else if (grant) begin
         out_valid_q <= 1'b1;
         out_data_q  <= fu_result_i[winner];
         rr_ptr_q    <= rr_ptr_d;
      end else if (flush_i || wb_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign wb_valid_o  = out_valid_q;
   assign wb_result_o = out_data_q;

   a_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(fu_ready_o));
   a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      (fu_ready_o & ~fu_valid_i) == '0);
   a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (wb_valid_o && !wb_ready_i) |=> $stable(wb_result_o));

endmodule
